// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared encodings and field positions for the CSR execute stage
package csr_pkg;

  localparam logic [1:0] CSR_OP_NONE = 2'b00;
  localparam logic [1:0] CSR_OP_RW   = 2'b01;
  localparam logic [1:0] CSR_OP_RS   = 2'b10;
  localparam logic [1:0] CSR_OP_RC   = 2'b11;
  localparam int         CSR_OP_IMM  = 2;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  // Address bits [11:10]==11 mark read-only CSRs; [9:8] give the lowest privilege allowed.
  localparam int CSR_RO_HI   = 11;
  localparam int CSR_RO_LO   = 10;
  localparam int CSR_PRIV_HI = 9;
  localparam int CSR_PRIV_LO = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } csr_state_e;

endpackage

// File: rtl/csr_exec_unit_if.sv
// rtl/csr_exec_unit_if.sv - request/response and hardware-update bus of the CSR execute stage
interface csr_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [11:0]     req_addr;
  logic [4:0]      req_rd;
  logic [4:0]      req_rs1_idx;
  logic [XLEN-1:0] req_rs1_data;
  logic [1:0]      req_priv;

  logic            resp_valid;
  logic            resp_ready;
  logic [4:0]      resp_rd;
  logic            resp_rd_we;
  logic [XLEN-1:0] resp_rd_data;
  logic            resp_illegal;

  logic            hw_we;
  logic [11:0]     hw_addr;
  logic [XLEN-1:0] hw_wdata;

  modport master (
    output req_valid, req_op, req_addr, req_rd, req_rs1_idx, req_rs1_data, req_priv,
    output resp_ready, hw_we, hw_addr, hw_wdata,
    input  req_ready, resp_valid, resp_rd, resp_rd_we, resp_rd_data, resp_illegal
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_rd, req_rs1_idx, req_rs1_data, req_priv,
    input  resp_ready, hw_we, hw_addr, hw_wdata,
    output req_ready, resp_valid, resp_rd, resp_rd_we, resp_rd_data, resp_illegal
  );
endinterface

// File: rtl/csr_addr_match.sv
// rtl/csr_addr_match.sv - maps a 12-bit CSR address to its slot in the local CSR file
module csr_addr_match #(
  parameter int                    NUM_CSR   = 8,
  parameter int                    IDXW      = 3,
  parameter logic [12*NUM_CSR-1:0] CSR_ADDRS = '0
) (
  input  logic [11:0]     i_addr,
  output logic            o_hit,
  output logic [IDXW-1:0] o_idx
);

  // Scan from the top down so that the lowest matching slot is the one left standing.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = NUM_CSR - 1; i >= 0; i--) begin
      if (CSR_ADDRS[12*i +: 12] == i_addr) begin
        o_hit = 1'b1;
        o_idx = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/csr_exec_unit.sv
// rtl/csr_exec_unit.sv - sequential Zicsr execute stage with a local parametrised CSR file
module csr_exec_unit
  import csr_pkg::*;
#(
  parameter int                         XLEN       = 32,
  parameter int                         NUM_CSR    = 8,
  parameter logic [12*NUM_CSR-1:0]      CSR_ADDRS  = {NUM_CSR{12'h000}},
  parameter logic [NUM_CSR*XLEN-1:0]    CSR_RESETS = {NUM_CSR*XLEN{1'b0}}
) (
  input  logic                      clk,
  input  logic                      rst,
  csr_exec_unit_if.slave            bus,
  output logic [NUM_CSR*XLEN-1:0]   csr_flat
);

  localparam int IDXW = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1;

  csr_state_e      r_state;
  logic [2:0]      r_op;
  logic [11:0]     r_addr;
  logic [4:0]      r_rd;
  logic [4:0]      r_rs1_idx;
  logic [XLEN-1:0] r_rs1_data;
  logic [1:0]      r_priv;
  logic [XLEN-1:0] r_csr [NUM_CSR];

  logic            r_resp_valid;
  logic [4:0]      r_resp_rd;
  logic            r_resp_rd_we;
  logic [XLEN-1:0] r_resp_rd_data;
  logic            r_resp_illegal;

  logic            w_req_hit;
  logic [IDXW-1:0] w_req_idx;
  logic            w_hw_hit;
  logic [IDXW-1:0] w_hw_idx;
  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_src;
  logic [XLEN-1:0] w_new;
  logic            w_write_intent;
  logic            w_read_intent;
  logic            w_illegal;
  logic            w_sw_we;
  logic            w_hw_we;

  csr_addr_match #(.NUM_CSR(NUM_CSR), .IDXW(IDXW), .CSR_ADDRS(CSR_ADDRS)) u_req_match (
    .i_addr (r_addr),
    .o_hit  (w_req_hit),
    .o_idx  (w_req_idx)
  );

  csr_addr_match #(.NUM_CSR(NUM_CSR), .IDXW(IDXW), .CSR_ADDRS(CSR_ADDRS)) u_hw_match (
    .i_addr (bus.hw_addr),
    .o_hit  (w_hw_hit),
    .o_idx  (w_hw_idx)
  );

  // Old value is read live in EXEC, so it reflects every write committed up to EXEC entry.
  assign w_old = w_req_hit ? r_csr[w_req_idx] : '0;
  assign w_src = r_op[CSR_OP_IMM] ? {{(XLEN-5){1'b0}}, r_rs1_idx} : r_rs1_data;

  always_comb begin
    w_new = w_src;
    case (r_op[1:0])
      CSR_OP_RS: w_new = w_old | w_src;
      CSR_OP_RC: w_new = w_old & ~w_src;
      default:   w_new = w_src;
    endcase
  end

  assign w_write_intent = (r_op[1:0] == CSR_OP_RW) || (r_rs1_idx != 5'd0);
  assign w_read_intent  = (r_op[1:0] != CSR_OP_RW) || (r_rd != 5'd0);
  assign w_illegal      = (r_op[1:0] == CSR_OP_NONE) || !w_req_hit
                        || (r_priv < r_addr[CSR_PRIV_HI:CSR_PRIV_LO])
                        || (w_write_intent && (r_addr[CSR_RO_HI:CSR_RO_LO] == 2'b11));
  assign w_sw_we        = (r_state == ST_EXEC) && w_write_intent && !w_illegal;
  assign w_hw_we        = bus.hw_we && w_hw_hit;

  // Software commit takes precedence over a hardware update to the same slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CSR; i++) r_csr[i] <= CSR_RESETS[XLEN*i +: XLEN];
    end else begin
      for (int i = 0; i < NUM_CSR; i++) begin
        if (w_sw_we && (w_req_idx == IDXW'(i))) r_csr[i] <= w_new;
        else if (w_hw_we && (w_hw_idx == IDXW'(i))) r_csr[i] <= bus.hw_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_op           <= '0;
      r_addr         <= '0;
      r_rd           <= '0;
      r_rs1_idx      <= '0;
      r_rs1_data     <= '0;
      r_priv         <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_rd      <= '0;
      r_resp_rd_we   <= 1'b0;
      r_resp_rd_data <= '0;
      r_resp_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_op       <= bus.req_op;
            r_addr     <= bus.req_addr;
            r_rd       <= bus.req_rd;
            r_rs1_idx  <= bus.req_rs1_idx;
            r_rs1_data <= bus.req_rs1_data;
            r_priv     <= bus.req_priv;
            r_state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_resp_valid   <= 1'b1;
          r_resp_rd      <= r_rd;
          r_resp_rd_we   <= w_read_intent && (r_rd != 5'd0) && !w_illegal;
          r_resp_rd_data <= w_illegal ? '0 : w_old;
          r_resp_illegal <= w_illegal;
          r_state        <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid   <= 1'b0;
            r_resp_rd      <= '0;
            r_resp_rd_we   <= 1'b0;
            r_resp_rd_data <= '0;
            r_resp_illegal <= 1'b0;
            r_state        <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (r_state == ST_IDLE) && !rst;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_rd      = r_resp_rd;
  assign bus.resp_rd_we   = r_resp_rd_we;
  assign bus.resp_rd_data = r_resp_rd_data;
  assign bus.resp_illegal = r_resp_illegal;

  always_comb begin
    csr_flat = '0;
    for (int i = 0; i < NUM_CSR; i++) csr_flat[XLEN*i +: XLEN] = r_csr[i];
  end

endmodule

// File: tb/tb_csr_exec_unit.sv
// tb/tb_csr_exec_unit.sv - scoreboard bench for csr_exec_unit with directed Zicsr vectors
module tb_csr_exec_unit;
  import csr_pkg::*;

  localparam logic [35:0] ADDRS  = {12'hC00, 12'h300, 12'h340};
  localparam logic [95:0] RESETS = {32'h12345678, 32'h00001800, 32'h00000000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [95:0] csr_flat;

  csr_exec_unit_if #(.XLEN(32)) u_if ();

  csr_exec_unit #(
    .XLEN(32), .NUM_CSR(3), .CSR_ADDRS(ADDRS), .CSR_RESETS(RESETS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (u_if),
    .csr_flat (csr_flat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && u_if.resp_valid && u_if.resp_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: got response rd=%0d data=%0h, expected none",
                   u_if.resp_rd, u_if.resp_rd_data);
        end else begin
          e = sb_q.pop_front();
          check("resp_rd",      u_if.resp_rd,      e.rd);
          check("resp_rd_we",   u_if.resp_rd_we,   e.we);
          check("resp_rd_data", u_if.resp_rd_data, e.data);
          check("resp_illegal", u_if.resp_illegal, e.ill);
        end
      end
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [11:0] addr, input logic [4:0] rd,
                       input logic [4:0] rs1_idx, input logic [31:0] rs1_data,
                       input logic [1:0] priv, input logic exp_we, input logic [31:0] exp_data,
                       input logic exp_ill, input int hold, input logic exec_hw,
                       input logic [11:0] hw_a, input logic [31:0] hw_d);
    exp_t e;
    @(negedge clk);
    check("req_ready_idle", u_if.req_ready, 1'b1);
    u_if.req_op       = op;
    u_if.req_addr     = addr;
    u_if.req_rd       = rd;
    u_if.req_rs1_idx  = rs1_idx;
    u_if.req_rs1_data = rs1_data;
    u_if.req_priv     = priv;
    u_if.req_valid    = 1'b1;
    e.rd = rd; e.we = exp_we; e.data = exp_data; e.ill = exp_ill;
    sb_q.push_back(e);
    @(posedge clk); #1;
    u_if.req_valid = 1'b0;
    if (exec_hw) begin
      u_if.hw_we    = 1'b1;
      u_if.hw_addr  = hw_a;
      u_if.hw_wdata = hw_d;
    end
    @(negedge clk);
    check("exec_no_resp", u_if.resp_valid, 1'b0);
    @(posedge clk); #1;
    u_if.hw_we = 1'b0;
    @(negedge clk);
    check("resp_latency", u_if.resp_valid, 1'b1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_valid",     u_if.resp_valid,   1'b1);
      check("hold_req_ready", u_if.req_ready,    1'b0);
      check("hold_data",      u_if.resp_rd_data, exp_data);
    end
    @(posedge clk); #1;
    u_if.resp_ready = 1'b1;
    @(posedge clk); #1;
    u_if.resp_ready = 1'b0;
  endtask

  task automatic hw_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    u_if.hw_we    = 1'b1;
    u_if.hw_addr  = a;
    u_if.hw_wdata = d;
    @(posedge clk); #1;
    u_if.hw_we = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    u_if.req_valid = 1'b0; u_if.req_op = '0; u_if.req_addr = '0; u_if.req_rd = '0;
    u_if.req_rs1_idx = '0; u_if.req_rs1_data = '0; u_if.req_priv = PRIV_M;
    u_if.resp_ready = 1'b0; u_if.hw_we = 1'b0; u_if.hw_addr = '0; u_if.hw_wdata = '0;

    repeat (2) @(negedge clk);
    check("rst_req_ready",  u_if.req_ready,  1'b0);
    check("rst_resp_valid", u_if.resp_valid, 1'b0);
    check("rst_csr_flat",   csr_flat,        RESETS);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", u_if.req_ready, 1'b1);

    // op, addr, rd, rs1_idx, rs1_data, priv, exp_we, exp_data, exp_ill, hold, exec_hw, hw_a, hw_d
    do_op(3'b001, 12'h340, 5'd5, 5'd1, 32'hDEADBEEF, PRIV_M, 1'b1, 32'h0, 1'b0, 0, 1'b0, 12'h0, 32'h0);
    check("mscratch_rw", csr_flat[31:0], 32'hDEADBEEF);
    do_op(3'b010, 12'h340, 5'd6, 5'd2, 32'h000000F0, PRIV_M, 1'b1, 32'hDEADBEEF, 1'b0, 0, 1'b0, 12'h0, 32'h0);
    check("mscratch_rs", csr_flat[31:0], 32'hDEADBEFF);
    do_op(3'b011, 12'h340, 5'd7, 5'd3, 32'hDEADBEEF, PRIV_M, 1'b1, 32'hDEADBEFF, 1'b0, 0, 1'b0, 12'h0, 32'h0);
    check("mscratch_rc", csr_flat[31:0], 32'h00000010);

    do_op(3'b110, 12'hC00, 5'd8, 5'd0, 32'hFFFFFFFF, PRIV_M, 1'b1, 32'h12345678, 1'b0, 0, 1'b0, 12'h0, 32'h0);
    check("cycle_rsi0_nowrite", csr_flat[95:64], 32'h12345678);
    do_op(3'b101, 12'hC00, 5'd9, 5'd3, 32'h0, PRIV_M, 1'b0, 32'h0, 1'b1, 0, 1'b0, 12'h0, 32'h0);
    check("cycle_rwi_ro", csr_flat[95:64], 32'h12345678);

    do_op(3'b010, 12'h300, 5'd10, 5'd1, 32'h00000008, PRIV_U, 1'b0, 32'h0, 1'b1, 0, 1'b0, 12'h0, 32'h0);
    check("mstatus_priv_u", csr_flat[63:32], 32'h00001800);
    do_op(3'b001, 12'h7C0, 5'd4, 5'd1, 32'h11111111, PRIV_M, 1'b0, 32'h0, 1'b1, 0, 1'b0, 12'h0, 32'h0);
    do_op(3'b000, 12'h340, 5'd3, 5'd1, 32'h22222222, PRIV_M, 1'b0, 32'h0, 1'b1, 0, 1'b0, 12'h0, 32'h0);
    check("mscratch_op0", csr_flat[31:0], 32'h00000010);

    do_op(3'b010, 12'h300, 5'd11, 5'd0, 32'hFFFFFFFF, PRIV_M, 1'b1, 32'h00001800, 1'b0, 5, 1'b0, 12'h0, 32'h0);
    check("mstatus_rs_x0", csr_flat[63:32], 32'h00001800);

    // Hardware write lands in the same cycle as the software commit to the same CSR.
    do_op(3'b001, 12'h340, 5'd0, 5'd4, 32'hAAAA5555, PRIV_M, 1'b0, 32'h00000010, 1'b0, 0, 1'b1, 12'h340, 32'h11111111);
    check("sw_wins_hw", csr_flat[31:0], 32'hAAAA5555);

    hw_write(12'h300, 32'hCAFEF00D);
    check("hw_write_mstatus", csr_flat[63:32], 32'hCAFEF00D);
    hw_write(12'h7C0, 32'hFFFFFFFF);
    check("hw_unmapped", csr_flat, {32'h12345678, 32'hCAFEF00D, 32'hAAAA5555});

    // Reset lands while the op is in EXEC: nothing may commit or respond.
    @(negedge clk);
    u_if.req_op = 3'b001; u_if.req_addr = 12'h340; u_if.req_rd = 5'd1;
    u_if.req_rs1_idx = 5'd1; u_if.req_rs1_data = 32'h00000055; u_if.req_priv = PRIV_M;
    u_if.req_valid = 1'b1;
    @(posedge clk); #1;
    u_if.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_exec_resp_valid", u_if.resp_valid, 1'b0);
    check("rst_exec_csr_flat",   csr_flat,        RESETS);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_exec_idle_no_resp", u_if.resp_valid, 1'b0);

    do_op(3'b001, 12'h340, 5'd2, 5'd1, 32'h00000077, PRIV_M, 1'b1, 32'h0, 1'b0, 0, 1'b0, 12'h0, 32'h0);
    check("mscratch_after_rst", csr_flat[31:0], 32'h00000077);

    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
